// File: rtl/wsat_pkg.sv
// Shared constants and types for the WalkSAT flip-selection datapath.
// Break-value width follows from the clause count so a full break vector never wraps.
package wsat_pkg;

    localparam int N_CLAUSE_DEF = 20;
    localparam int CNT_W_DEF    = $clog2(N_CLAUSE_DEF + 1);

    typedef logic [N_CLAUSE_DEF-1:0] brk_vec_t;
    typedef logic [CNT_W_DEF-1:0]    bv_cnt_t;

endpackage

// File: rtl/break_value_counter_popcount_tree.sv
// Purpose: combinational popcount of IN_W bits as a balanced binary adder tree.
// Latency: zero cycles; depth grows as log2(IN_W).
// Backpressure: none, pure function of the input.
module popcount_tree #(
    parameter int IN_W  = 20,
    parameter int OUT_W = 5
) (
    input  logic [IN_W-1:0]  in,
    output logic [OUT_W-1:0] out
);

    localparam int SUM_W = $clog2(IN_W + 1);

    logic [SUM_W-1:0] sum;

    generate
        if (IN_W == 1) begin : g_leaf
            assign sum = in;
        end else begin : g_node
            // Split as evenly as possible so both halves have equal depth.
            localparam int LO_W  = IN_W / 2;
            localparam int HI_W  = IN_W - LO_W;
            localparam int LO_SW = $clog2(LO_W + 1);
            localparam int HI_SW = $clog2(HI_W + 1);

            logic [LO_SW-1:0] lo_sum;
            logic [HI_SW-1:0] hi_sum;

            popcount_tree #(
                .IN_W  (LO_W),
                .OUT_W (LO_SW)
            ) u_lo (
                .in  (in[LO_W-1:0]),
                .out (lo_sum)
            );

            popcount_tree #(
                .IN_W  (HI_W),
                .OUT_W (HI_SW)
            ) u_hi (
                .in  (in[IN_W-1:LO_W]),
                .out (hi_sum)
            );

            // Each operand is widened to the full node width before adding so no carry is lost.
            assign sum = SUM_W'(lo_sum) + SUM_W'(hi_sum);
        end

        if (OUT_W == SUM_W) begin : g_out_eq
            assign out = sum;
        end else if (OUT_W > SUM_W) begin : g_out_ext
            assign out = {{(OUT_W-SUM_W){1'b0}}, sum};
        end else begin : g_out_trunc
            assign out = sum[OUT_W-1:0];
        end
    endgenerate

endmodule

// File: rtl/break_value_counter.sv
// Purpose: registered break value (number of set bits in brk) for one candidate flip.
// Latency: one cycle from brk sampled at a rising edge to count.
// Backpressure: none, a new vector is accepted and count updated every cycle.
module break_value_counter
    import wsat_pkg::*;
#(
    parameter int N_CLAUSE = N_CLAUSE_DEF,
    parameter int CNT_W    = CNT_W_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_CLAUSE-1:0] brk,
    output logic [CNT_W-1:0]    count
);

    generate
        if ((2 ** CNT_W) <= N_CLAUSE) begin : g_bad_width
            $error("break_value_counter: CNT_W too narrow for N_CLAUSE");
        end
    endgenerate

    logic [CNT_W-1:0] count_nxt;

    popcount_tree #(
        .IN_W  (N_CLAUSE),
        .OUT_W (CNT_W)
    ) u_popcount_tree (
        .in  (brk),
        .out (count_nxt)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else begin
            count <= count_nxt;
        end
    end

endmodule

// File: tb/tb_break_value_counter.sv
// Directed and random checks of the registered break-value counter.
module tb_break_value_counter;

    logic        clk;
    logic        rst;
    logic [19:0] brk;
    logic [4:0]  count;

    int checks_total;
    int checks_passed;

    break_value_counter #(
        .N_CLAUSE (20),
        .CNT_W    (5)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .brk   (brk),
        .count (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        brk = 20'hFFFFF;
        #1;
        checks_total++;
        if (count !== 5'd0) $display("FAIL reset_initial count=%0d expected=0", count);
        else checks_passed++;
        for (int i = 0; i < 2; i++) begin
            step();
            checks_total++;
            if (count !== 5'd0) $display("FAIL reset_hold cyc=%0d count=%0d expected=0", i, count);
            else checks_passed++;
        end
        rst = 1'b1;
        step();
        checks_total++;
        if (count !== 5'd20) $display("FAIL reset_release count=%0d expected=20", count);
        else checks_passed++;
    endtask

    task automatic test_basic();
        logic [19:0] vec [4];
        logic [4:0]  exp [4];
        vec = '{20'b10, 20'b111, 20'b1111, 20'h05556};
        exp = '{5'd1, 5'd3, 5'd4, 5'd8};
        for (int i = 0; i < 4; i++) begin
            brk = vec[i];
            step();
            checks_total++;
            if (count !== exp[i]) $display("FAIL basic brk=%05h count=%0d expected=%0d", vec[i], count, exp[i]);
            else checks_passed++;
        end
    endtask

    task automatic test_extremes();
        logic [19:0] vec [3];
        logic [4:0]  exp [3];
        vec = '{20'h00000, 20'hFFFFF, 20'h80001};
        exp = '{5'd0, 5'd20, 5'd2};
        for (int i = 0; i < 3; i++) begin
            brk = vec[i];
            step();
            checks_total++;
            if (count !== exp[i]) $display("FAIL extremes brk=%05h count=%0d expected=%0d", vec[i], count, exp[i]);
            else checks_passed++;
        end
    endtask

    task automatic test_back_to_back();
        logic [19:0] vec [3];
        logic [4:0]  exp [3];
        vec = '{20'hAAAAA, 20'h55555, 20'h00001};
        exp = '{5'd10, 5'd10, 5'd1};
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 3; i++) begin
                brk = vec[i];
                step();
                checks_total++;
                if (count !== exp[i]) $display("FAIL back_to_back rep=%0d brk=%05h count=%0d expected=%0d", r, vec[i], count, exp[i]);
                else checks_passed++;
            end
        end
    endtask

    task automatic test_reset_mid();
        brk = 20'hFFFFF;
        step();
        checks_total++;
        if (count !== 5'd20) $display("FAIL mid_pre count=%0d expected=20", count);
        else checks_passed++;
        #2;
        rst = 1'b0;
        #1;
        checks_total++;
        if (count !== 5'd0) $display("FAIL mid_async_clear count=%0d expected=0", count);
        else checks_passed++;
        brk = 20'h00007;
        step();
        checks_total++;
        if (count !== 5'd0) $display("FAIL mid_held count=%0d expected=0", count);
        else checks_passed++;
        rst = 1'b1;
        step();
        checks_total++;
        if (count !== 5'd3) $display("FAIL mid_resume count=%0d expected=3", count);
        else checks_passed++;
    endtask

    task automatic test_random();
        logic [4:0] exp;
        for (int i = 0; i < 1000; i++) begin
            brk = 20'($urandom);
            exp = 5'($countones(brk));
            step();
            checks_total++;
            if (count !== exp) $display("FAIL random i=%0d brk=%05h count=%0d expected=%0d", i, brk, count, exp);
            else checks_passed++;
        end
    endtask

    initial begin
        checks_total  = 0;
        checks_passed = 0;
        rst = 1'b0;
        brk = '0;
        test_reset();
        test_basic();
        test_extremes();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
